// File: rtl/apb_share_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing and an
// ACCESS-phase timeout that aborts transfers the completer never finishes.
module apb_share_arbiter #(
    parameter int unsigned APB_AW         = 10,
    parameter int unsigned APB_DW         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic              m0_req,
    input  logic [APB_AW-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [APB_DW-1:0] m0_wdata,
    output logic              m0_done,
    output logic [APB_DW-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [APB_AW-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [APB_DW-1:0] m1_wdata,
    output logic              m1_done,
    output logic [APB_DW-1:0] m1_rdata,
    output logic              m1_err,
    output logic [APB_AW-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy,
    output logic              timeout_evt
);

    localparam int unsigned CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state;
    logic          owner;
    logic          last_grant;
    logic          pick1;
    logic [CW-1:0] cnt;

    // m1 wins when it is the only requester, or on contention when m0 went last
    always_comb begin
        pick1 = m1_req && (!m0_req || !last_grant);
    end

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            PADDR       <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            m0_done     <= 1'b0;
            m0_rdata    <= '0;
            m0_err      <= 1'b0;
            m1_done     <= 1'b0;
            m1_rdata    <= '0;
            m1_err      <= 1'b0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            m0_done     <= 1'b0;
            m0_err      <= 1'b0;
            m1_done     <= 1'b0;
            m1_err      <= 1'b0;
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= pick1;
                        last_grant <= pick1;
                        PADDR      <= pick1 ? m1_addr  : m0_addr;
                        PWRITE     <= pick1 ? m1_write : m0_write;
                        PWDATA     <= pick1 ? m1_wdata : m0_wdata;
                        PSEL       <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        state   <= DONE;
                        if (owner) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= PRDATA;
                            m1_err   <= PSLVERR;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= PRDATA;
                            m0_err   <= PSLVERR;
                        end
                    end else if (TIMEOUT_CYCLES != 0 && cnt == CW'(TLIM)) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        timeout_evt <= 1'b1;
                        state       <= DONE;
                        if (owner) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= '0;
                            m1_err   <= 1'b1;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= '0;
                            m0_err   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_share_arbiter.sv
// Directed + randomized bench for apb_share_arbiter with a transaction-level
// reference model (grant order, access length, timeout outcome, held rdata).
module tb_apb_share_arbiter;

    localparam int TO = 8;

    logic        clk_in = 1'b0;
    logic        reset_int;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [9:0]  m0_addr, m1_addr, PADDR;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, PWDATA, PRDATA;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy, timeout_evt;

    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_last;
    logic [31:0] exp_rdata [2];

    apb_share_arbiter #(.APB_AW(10), .APB_DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .reset_int(reset_int),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts in an IDLE cycle (#1 after posedge) and ends in the following IDLE cycle.
    // waits = PREADY-low ACCESS cycles before PREADY; waits >= TO means the slave never answers.
    task automatic xfer(input logic r0, input logic r1, input int waits,
                        input logic wr0, input logic wr1,
                        input logic [9:0] a0, input logic [9:0] a1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [31:0] rd, input logic se);
        logic [9:0]  a  [2];
        logic [31:0] wd [2];
        logic        wr [2];
        logic        own;
        logic        to;
        logic        eerr;
        int          nacc;
        a[0] = a0;  a[1] = a1;  wd[0] = wd0; wd[1] = wd1; wr[0] = wr0; wr[1] = wr1;
        m0_req = r0; m0_addr = a0; m0_write = wr0; m0_wdata = wd0;
        m1_req = r1; m1_addr = a1; m1_write = wr1; m1_wdata = wd1;
        own      = (r0 && r1) ? ~exp_last : r1;
        exp_last = own;
        to       = (waits >= TO);
        nacc     = to ? TO : waits + 1;
        eerr     = to ? 1'b1 : se;

        @(posedge clk_in) #1;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, a[own]);
        chk("setup_pwrite", PWRITE, wr[own]);
        chk("setup_pwdata", PWDATA, wd[own]);
        chk("setup_busy", busy, 1);
        // requester inputs change mid-transfer and must be ignored
        m0_addr = 10'($urandom); m0_wdata = $urandom; m0_write = ~wr0;
        m1_addr = 10'($urandom); m1_wdata = $urandom; m1_write = ~wr1;

        @(posedge clk_in) #1;
        for (int k = 0; k < nacc; k++) begin
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, a[own]);
            chk("access_pwdata", PWDATA, wd[own]);
            chk("access_done", {m0_done, m1_done}, 0);
            PREADY  = (!to && k == waits);
            PRDATA  = PREADY ? rd : $urandom;
            PSLVERR = PREADY ? se : 1'($urandom);
            @(posedge clk_in) #1;
        end
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0;

        exp_rdata[own] = to ? 32'h0 : rd;
        chk("done_psel", PSEL, 0);
        chk("done_penable", PENABLE, 0);
        chk("done_busy", busy, 1);
        chk("done_m0", m0_done, own == 1'b0);
        chk("done_m1", m1_done, own == 1'b1);
        chk("done_m0_err", m0_err, (own == 1'b0) && eerr);
        chk("done_m1_err", m1_err, (own == 1'b1) && eerr);
        chk("done_m0_rdata", m0_rdata, exp_rdata[0]);
        chk("done_m1_rdata", m1_rdata, exp_rdata[1]);
        chk("done_timeout_evt", timeout_evt, to);
        if (own) m1_req = 1'b0; else m0_req = 1'b0;

        @(posedge clk_in) #1;
        chk("idle_busy", busy, 0);
        chk("idle_psel", PSEL, 0);
        chk("idle_done", {m0_done, m1_done, m0_err, m1_err, timeout_evt}, 0);
        chk("idle_m0_rdata", m0_rdata, exp_rdata[0]);
        chk("idle_m1_rdata", m1_rdata, exp_rdata[1]);
    endtask

    initial begin
        reset_int = 1'b0;
        m0_req = 0; m0_addr = '0; m0_write = 0; m0_wdata = '0;
        m1_req = 0; m1_addr = '0; m1_write = 0; m1_wdata = '0;
        PRDATA = '0; PREADY = 0; PSLVERR = 0;
        exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;

        #3;
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, busy, timeout_evt, m0_done, m0_err, m1_done, m1_err}, 0);
        chk("reset_buses", {PADDR, PWDATA, m0_rdata, m1_rdata}, 0);
        @(negedge clk_in); @(negedge clk_in);
        reset_int = 1'b1;
        @(posedge clk_in) #1;

        // continuous contention alternates starting with m0
        for (int i = 0; i < 4; i++)
            xfer(1, 1, $urandom_range(0, 2), 1'($urandom), 1'($urandom),
                 10'($urandom), 10'($urandom), $urandom, $urandom, $urandom, 1'($urandom));

        // single read, wait-state error write, timeout, last-cycle completion
        xfer(1, 0, 0, 0, 0, 10'h010, 10'h0, 32'h0, 32'h0, 32'hDEADBEEF, 0);
        xfer(0, 1, 5, 0, 1, 10'h0, 10'h3FC, 32'h0, 32'h0000_00A5, $urandom, 1);
        xfer(1, 0, 100, 0, 0, 10'h155, 10'h0, 32'h0, 32'h0, $urandom, 0);
        xfer(1, 0, TO - 1, 1, 0, 10'h2AA, 10'h0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            xfer(rq[0], rq[1], $urandom_range(0, 9), 1'($urandom), 1'($urandom),
                 10'($urandom), 10'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
        end

        // reset during the 3rd wait cycle of an m1 access
        m0_req = 0; m1_req = 1; m1_addr = 10'h0AB; m1_write = 1; m1_wdata = $urandom;
        @(posedge clk_in) #1;
        chk("rst_setup_psel", PSEL, 1);
        @(posedge clk_in) #1;
        @(posedge clk_in) #1;
        @(posedge clk_in) #1;
        chk("rst_access_penable", PENABLE, 1);
        #2 reset_int = 1'b0;
        #1;
        chk("rst_async_psel", PSEL, 0);
        chk("rst_async_penable", PENABLE, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rdata", {m0_rdata, m1_rdata}, 0);
        m1_req = 0;
        @(posedge clk_in) #1;
        chk("rst_no_done", {m0_done, m1_done, m0_err, m1_err, timeout_evt}, 0);
        @(negedge clk_in);
        reset_int = 1'b1;
        exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(posedge clk_in) #1;
        xfer(1, 1, 1, 0, 0, 10'($urandom), 10'($urandom), $urandom, $urandom, $urandom, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
